// File: rtl/seq_disp_pkg.sv
`default_nettype none
// ============================================================================
// Module   : seq_disp_pkg
// Purpose  : Shared constants for the sequence display driver: active-low
//            seven-segment glyphs, direction encodings, converter states.
// Revision : 1.0 - initial release
// ============================================================================
package seq_disp_pkg;

    // Segment order is {g,f,e,d,c,b,a}; a 0 lights the segment.
    localparam logic [6:0] SEG_DIGIT [0:9] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
        7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
    };

    localparam logic [6:0] SEG_U     = 7'b1000001;
    localparam logic [6:0] SEG_D     = 7'b0100001;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [1:0] DIR_EQ    = 2'b00;
    localparam logic [1:0] DIR_UP    = 2'b01;
    localparam logic [1:0] DIR_DOWN  = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CONV = 2'd1,
        ST_DONE = 2'd2
    } conv_state_e;

    // Digit glyph; anything outside 0..9 shows as blank.
    function automatic logic [6:0] seg_digit(input logic [3:0] d);
        if (d <= 4'd9) seg_digit = SEG_DIGIT[d];
        else           seg_digit = SEG_BLANK;
    endfunction

    // Direction glyph: up 'U', down 'd', otherwise '-'.
    function automatic logic [6:0] dir_glyph(input logic [1:0] d);
        case (d)
            DIR_UP:   dir_glyph = SEG_U;
            DIR_DOWN: dir_glyph = SEG_D;
            default:  dir_glyph = SEG_DASH;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/seq_display_driver_bin2bcd.sv
`default_nettype none
// ============================================================================
// Module   : bin2bcd_seq
// Purpose  : Sequential double-dabble converter, one shift per clock.
//            start is accepted in IDLE and in the DONE cycle; done is high
//            for exactly the one DONE cycle while tens/ones hold the result.
// Revision : 1.0 - initial release
// ============================================================================
module bin2bcd_seq
    import seq_disp_pkg::*;
#(
    parameter int VAL_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [VAL_W-1:0] din,
    output logic             busy,
    output logic             done,
    output logic [3:0]       tens,
    output logic [3:0]       ones
);

    localparam logic [1:0] S_IDLE = ST_IDLE;
    localparam logic [1:0] S_CONV = ST_CONV;
    localparam logic [1:0] S_DONE = ST_DONE;
    localparam logic [2:0] LAST_ITER = 3'(VAL_W - 1);

    logic [1:0]        r_state;
    logic [VAL_W-1:0]  r_bin;
    logic [7:0]        r_bcd;
    logic [2:0]        r_iter;

    logic [3:0]        w_ones_adj;
    logic [3:0]        w_tens_adj;
    logic [VAL_W+7:0]  w_cat_sh;

    // One double-dabble step: correct nibbles >= 5, then shift the pair left.
    always_comb begin
        w_ones_adj = (r_bcd[3:0] >= 4'd5) ? r_bcd[3:0] + 4'd3 : r_bcd[3:0];
        w_tens_adj = (r_bcd[7:4] >= 4'd5) ? r_bcd[7:4] + 4'd3 : r_bcd[7:4];
        w_cat_sh   = {w_tens_adj, w_ones_adj, r_bin} << 1;
    end

    // Converter state machine and datapath.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_bin   <= '0;
            r_bcd   <= '0;
            r_iter  <= '0;
        end else begin
            case (r_state)
                S_CONV: begin
                    r_bcd <= w_cat_sh[VAL_W+7:VAL_W];
                    r_bin <= w_cat_sh[VAL_W-1:0];
                    if (r_iter == LAST_ITER) begin
                        r_state <= S_DONE;
                    end else begin
                        r_iter <= r_iter + 3'd1;
                    end
                end
                default: begin
                    // IDLE and DONE both accept a new start.
                    if (start) begin
                        r_bin   <= din;
                        r_bcd   <= '0;
                        r_iter  <= '0;
                        r_state <= S_CONV;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
            endcase
        end
    end

    assign busy = (r_state != S_IDLE);
    assign done = (r_state == S_DONE);
    assign tens = r_bcd[7:4];
    assign ones = r_bcd[3:0];

endmodule
`default_nettype wire

// File: rtl/seq_display_driver.sv
`default_nettype none
// ============================================================================
// Module   : seq_display_driver
// Purpose  : Samples the sequence counter on a strobe, converts it to BCD,
//            tracks direction and peak count, and scans four active-low
//            seven-segment digits (ones, tens, direction, peaks).
// Revision : 1.0 - initial release
// ============================================================================
module seq_display_driver
    import seq_disp_pkg::*;
#(
    parameter int SCAN_DIV = 100000,
    parameter int VAL_W    = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [VAL_W-1:0] value,
    input  logic             in_en,
    output logic             busy,
    output logic [3:0]       bcd_tens,
    output logic [3:0]       bcd_ones,
    output logic [1:0]       dir,
    output logic [3:0]       peak_cnt,
    output logic [3:0]       an,
    output logic [6:0]       seg
);

    localparam int              CNT_W   = $clog2(SCAN_DIV);
    localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(SCAN_DIV - 1);
    localparam logic [VAL_W-1:0] VAL_MAX = '1;

    logic             w_conv_busy;
    logic             w_conv_done;
    logic [3:0]       w_conv_tens;
    logic [3:0]       w_conv_ones;
    logic             w_start;
    logic [VAL_W-1:0] w_start_val;

    logic             r_pend;
    logic [VAL_W-1:0] r_pend_val;
    logic [VAL_W-1:0] r_cur;
    logic [VAL_W-1:0] r_prev;
    logic [3:0]       r_tens;
    logic [3:0]       r_ones;
    logic [1:0]       r_dir;
    logic [3:0]       r_peak;

    logic [CNT_W-1:0] r_scan_cnt;
    logic [1:0]       r_scan_idx;
    logic [3:0]       r_an;
    logic [6:0]       r_seg;
    logic             w_scan_tc;
    logic [1:0]       w_idx_next;
    logic [6:0]       w_glyph;

    bin2bcd_seq #(
        .VAL_W (VAL_W)
    ) u_bin2bcd (
        .clk   (clk),
        .rst   (rst),
        .start (w_start),
        .din   (w_start_val),
        .busy  (w_conv_busy),
        .done  (w_conv_done),
        .tens  (w_conv_tens),
        .ones  (w_conv_ones)
    );

    // Choose what to convert next: pending data on DONE, otherwise a fresh
    // strobe (newest) or leftover pending data once the converter is idle.
    always_comb begin
        w_start     = 1'b0;
        w_start_val = r_pend_val;
        if (w_conv_done) begin
            w_start = r_pend;
        end else if (!w_conv_busy) begin
            if (in_en) begin
                w_start     = 1'b1;
                w_start_val = value;
            end else if (r_pend) begin
                w_start = 1'b1;
            end
        end
    end

    // One-deep pending buffer for strobes that arrive while converting.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pend     <= 1'b0;
            r_pend_val <= '0;
        end else if (w_conv_busy && in_en) begin
            r_pend     <= 1'b1;
            r_pend_val <= value;
        end else if (w_start) begin
            r_pend     <= 1'b0;
        end
    end

    // Binary copy of the sample in flight, needed for direction and peak.
    always_ff @(posedge clk) begin
        if (rst)          r_cur <= '0;
        else if (w_start) r_cur <= w_start_val;
    end

    // Commit the finished conversion together with direction and peak count.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tens <= '0;
            r_ones <= '0;
            r_dir  <= DIR_EQ;
            r_peak <= '0;
            r_prev <= '0;
        end else if (w_conv_done) begin
            r_tens <= w_conv_tens;
            r_ones <= w_conv_ones;
            r_prev <= r_cur;
            if (r_cur > r_prev)      r_dir <= DIR_UP;
            else if (r_cur < r_prev) r_dir <= DIR_DOWN;
            else                     r_dir <= DIR_EQ;
            if (r_cur == VAL_MAX && r_prev != VAL_MAX) begin
                r_peak <= (r_peak == 4'd9) ? 4'd0 : r_peak + 4'd1;
            end
        end
    end

    // Glyph for the digit slot that becomes active on this edge.
    always_comb begin
        w_scan_tc  = (r_scan_cnt == CNT_TC);
        w_idx_next = w_scan_tc ? r_scan_idx + 2'd1 : r_scan_idx;
        case (w_idx_next)
            2'd0:    w_glyph = seg_digit(r_ones);
            2'd1:    w_glyph = (r_tens == 4'd0) ? SEG_BLANK : seg_digit(r_tens);
            2'd2:    w_glyph = dir_glyph(r_dir);
            default: w_glyph = seg_digit(r_peak);
        endcase
    end

    // Free-running scan; anode and segments are registered together.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_scan_cnt <= '0;
            r_scan_idx <= '0;
            r_an       <= 4'b1110;
            r_seg      <= SEG_DIGIT[0];
        end else begin
            r_scan_cnt <= w_scan_tc ? '0 : r_scan_cnt + CNT_W'(1);
            r_scan_idx <= w_idx_next;
            r_an       <= ~(4'b0001 << w_idx_next);
            r_seg      <= w_glyph;
        end
    end

    assign busy     = w_conv_busy;
    assign bcd_tens = r_tens;
    assign bcd_ones = r_ones;
    assign dir      = r_dir;
    assign peak_cnt = r_peak;
    assign an       = r_an;
    assign seg      = r_seg;

endmodule
`default_nettype wire

// File: tb/tb_seq_display_driver.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_display_driver
// Purpose  : Self-checking bench for seq_display_driver with a cycle-level
//            transaction model, a table of sequence vectors, directed corner
//            cases and randomized strobes.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seq_display_driver;

    localparam int SCAN_DIV = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_en = 1'b0;
    logic [5:0] value = '0;
    logic       busy;
    logic [3:0] bcd_tens, bcd_ones, peak_cnt, an;
    logic [1:0] dir;
    logic [6:0] seg;

    seq_display_driver #(.SCAN_DIV(SCAN_DIV), .VAL_W(6)) dut (
        .clk(clk), .rst(rst), .value(value), .in_en(in_en), .busy(busy),
        .bcd_tens(bcd_tens), .bcd_ones(bcd_ones), .dir(dir),
        .peak_cnt(peak_cnt), .an(an), .seg(seg)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: conversion age (0 idle, 1..7 cycles since start),
    // one pending slot, committed results and cycles since reset.
    int         m_c, m_cur, m_pval, m_tens, m_ones, m_peak, m_prev, m_n;
    bit         m_pv;
    logic [1:0] m_dir;
    logic [3:0] m_an;
    logic [6:0] m_seg;

    function automatic logic [6:0] digit_glyph(input int d);
        case (d)
            0: return 7'b1000000;  1: return 7'b1111001;
            2: return 7'b0100100;  3: return 7'b0110000;
            4: return 7'b0011001;  5: return 7'b0010010;
            6: return 7'b0000010;  7: return 7'b1111000;
            8: return 7'b0000000;  9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic logic [6:0] slot_glyph(input int idx);
        case (idx)
            0: return digit_glyph(m_ones);
            1: return (m_tens == 0) ? 7'b1111111 : digit_glyph(m_tens);
            2: return (m_dir == 2'b01) ? 7'b1000001 :
                      (m_dir == 2'b10) ? 7'b0100001 : 7'b0111111;
            default: return digit_glyph(m_peak);
        endcase
    endfunction

    task automatic model_edge();
        int  idx;
        bit  was_busy;
        if (rst) begin
            m_c = 0; m_pv = 0; m_pval = 0; m_cur = 0;
            m_tens = 0; m_ones = 0; m_peak = 0; m_prev = 0; m_dir = 2'b00;
            m_n = 0; m_an = 4'b1110; m_seg = 7'b1000000;
            return;
        end
        m_n++;
        idx   = (m_n / SCAN_DIV) % 4;
        m_an  = ~(4'b0001 << idx);
        m_seg = slot_glyph(idx);
        was_busy = (m_c != 0);
        if (m_c == 7) begin
            m_tens = m_cur / 10;
            m_ones = m_cur % 10;
            m_dir  = (m_cur > m_prev) ? 2'b01 : (m_cur < m_prev) ? 2'b10 : 2'b00;
            if (m_cur == 63 && m_prev != 63) m_peak = (m_peak + 1) % 10;
            m_prev = m_cur;
            if (m_pv) begin m_cur = m_pval; m_pv = 0; m_c = 1; end
            else m_c = 0;
        end else if (m_c > 0) begin
            m_c++;
        end else if (in_en) begin
            m_cur = value; m_pv = 0; m_c = 1;
        end else if (m_pv) begin
            m_cur = m_pval; m_pv = 0; m_c = 1;
        end
        if (was_busy && in_en) begin m_pv = 1; m_pval = value; end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                     name, act, act, exp, exp, $time);
        end
    endtask

    // One clock: model follows the edge, DUT compared on the falling edge.
    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check("busy", busy, (m_c != 0));
        check("tens", bcd_tens, m_tens);
        check("ones", bcd_ones, m_ones);
        check("dir", dir, m_dir);
        check("peak", peak_cnt, m_peak);
        check("an", an, m_an);
        check("seg", seg, m_seg);
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic pulse(input int v);
        value = 6'(v); in_en = 1'b1; step(); in_en = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1; step(); step(); rst = 1'b0;
    endtask

    typedef struct {
        int         v;
        int         tens;
        int         ones;
        logic [1:0] d;
        int         peak;
    } vec_t;

    vec_t seq_tab[8];

    initial begin
        int bcnt;
        seq_tab[0] = '{1,  0, 1, 2'b01, 0};
        seq_tab[1] = '{3,  0, 3, 2'b01, 0};
        seq_tab[2] = '{6,  0, 6, 2'b01, 0};
        seq_tab[3] = '{2,  0, 2, 2'b10, 0};
        seq_tab[4] = '{7,  0, 7, 2'b01, 0};
        seq_tab[5] = '{13, 1, 3, 2'b01, 0};
        seq_tab[6] = '{63, 6, 3, 2'b01, 1};
        seq_tab[7] = '{62, 6, 2, 2'b10, 1};

        // Reset and idle scan: digit 1 blank, digit 2 dash.
        do_reset();
        for (int i = 0; i < 20; i++) begin
            step();
            if (an == 4'b1101) check("digit1_blank", seg, 7'b1111111);
            if (an == 4'b1011) check("digit2_dash", seg, 7'b0111111);
        end
        check("idle_busy", busy, 0);

        // Single conversion of 37: busy for 7 cycles, then 3/7 going up.
        pulse(37);
        bcnt = 0;
        for (int i = 0; i < 20 && busy; i++) begin
            bcnt++;
            step();
        end
        check("busy_len_37", bcnt, 7);
        check("tens_37", bcd_tens, 3);
        check("ones_37", bcd_ones, 7);
        check("dir_37", dir, 2'b01);

        // Table of sequence values, one strobe every 10 cycles.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            pulse(seq_tab[i].v);
            idle(9);
            check($sformatf("tab%0d_tens", i), bcd_tens, seq_tab[i].tens);
            check($sformatf("tab%0d_ones", i), bcd_ones, seq_tab[i].ones);
            check($sformatf("tab%0d_dir", i), dir, seq_tab[i].d);
            check($sformatf("tab%0d_peak", i), peak_cnt, seq_tab[i].peak);
        end

        // Three strobes back to back: 63 is overwritten by 5 in pending.
        pulse(0); pulse(63); pulse(5);
        idle(20);
        check("b2b_tens", bcd_tens, 0);
        check("b2b_ones", bcd_ones, 5);
        check("b2b_dir", dir, 2'b01);
        check("b2b_peak", peak_cnt, 1);

        // Repeated 63 counts once; ten peaks wrap to 0.
        do_reset();
        pulse(63); idle(9);
        pulse(63); idle(9);
        check("peak_rep63", peak_cnt, 1);
        check("dir_rep63", dir, 2'b00);
        pulse(1); idle(9);
        for (int i = 0; i < 9; i++) begin
            pulse(63); idle(9);
            check($sformatf("peak_pass%0d", i + 2), peak_cnt, (i + 2) % 10);
            pulse(1); idle(9);
        end
        check("peak_wrap", peak_cnt, 0);

        // Reset during conversion of 45 discards it.
        do_reset();
        pulse(45);
        idle(2);
        rst = 1'b1; step(); rst = 1'b0;
        for (int i = 0; i < 15; i++) begin
            step();
            check("no_commit_45", {bcd_tens, bcd_ones}, 8'h00);
        end
        check("rst_mid_busy", busy, 0);

        // Randomized strobes against the model, with rare resets.
        do_reset();
        for (int i = 0; i < 800; i++) begin
            in_en = ($urandom_range(0, 4) == 0);
            value = ($urandom_range(0, 3) == 0) ? 6'd63 : 6'($urandom_range(0, 63));
            rst   = ($urandom_range(0, 299) == 0);
            step();
        end
        in_en = 1'b0; rst = 1'b0;
        idle(20);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
